// File: rtl/dfe_cfg_pkg.sv
// DFE configuration sequencer: shared FSM type and coefficient ROM layout.
package dfe_cfg_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LOAD,
        WR1,
        WR2,
        RD1,
        RD2,
        CMP,
        DONE
    } state_t;

    localparam int N_IIR_SEC = 3;

    // ROM word index of each segment base, plus the final word
    localparam int IDX_FRAC = 0;
    localparam int IDX_IIR  = 72;
    localparam int IDX_CIC  = 87;
    localparam int IDX_CTRL = 88;
    localparam int IDX_LAST = 88;

    localparam logic [3:0] MSEL_FRAC = 4'b0001;
    localparam logic [3:0] MSEL_IIR  = 4'b0010;
    localparam logic [3:0] MSEL_CIC  = 4'b0100;
    localparam logic [3:0] MSEL_CTRL = 4'b1000;

    localparam int EN_FRAC = 0;
    localparam int EN_IIR  = 1;
    localparam int EN_CIC  = 2;
    localparam int EN_CTRL = 3;

    localparam logic [1:0] SEG_FRAC = 2'd0;
    localparam logic [1:0] SEG_IIR  = 2'd1;
    localparam logic [1:0] SEG_CIC  = 2'd2;
    localparam logic [1:0] SEG_CTRL = 2'd3;

endpackage

// File: rtl/dfe_cfg_seg_map.sv
// Maps a ROM index to its bus target and finds the next enabled index.
module dfe_cfg_seg_map
    import dfe_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int COMP       = 4,
    parameter int ROM_AW     = 7,
    parameter int N_TAP      = 72,
    parameter int NUM_DENUM  = 5
) (
    input  logic [ROM_AW-1:0]     idx,
    input  logic [3:0]            seg_en,
    output logic [COMP-1:0]       msel,
    output logic [ADDR_WIDTH-1:0] maddr,
    output logic [ROM_AW-1:0]     next_idx,
    output logic                  last,
    output logic [ROM_AW-1:0]     first_idx,
    output logic                  none
);

    localparam int CIC_I = N_TAP + N_IIR_SEC * NUM_DENUM;

    localparam logic [ROM_AW-1:0] BASE_IIR  = ROM_AW'(N_TAP);
    localparam logic [ROM_AW-1:0] BASE_CIC  = ROM_AW'(CIC_I);
    localparam logic [ROM_AW-1:0] BASE_CTRL = ROM_AW'(CIC_I + 1);
    localparam logic [ROM_AW-1:0] ONE       = ROM_AW'(1);

    logic [1:0]        seg;
    logic [ROM_AW-1:0] seg_base;
    logic [ROM_AW-1:0] seg_last;
    logic [3:0]        sel;

    always_comb begin
        seg      = SEG_FRAC;
        seg_base = '0;
        seg_last = BASE_IIR - ONE;
        sel      = MSEL_FRAC;
        if (idx >= BASE_CTRL) begin
            seg      = SEG_CTRL;
            seg_base = BASE_CTRL;
            seg_last = BASE_CTRL;
            sel      = MSEL_CTRL;
        end else if (idx >= BASE_CIC) begin
            seg      = SEG_CIC;
            seg_base = BASE_CIC;
            seg_last = BASE_CIC;
            sel      = MSEL_CIC;
        end else if (idx >= BASE_IIR) begin
            seg      = SEG_IIR;
            seg_base = BASE_IIR;
            seg_last = BASE_CIC - ONE;
            sel      = MSEL_IIR;
        end
    end

    assign msel  = COMP'(sel);
    assign maddr = ADDR_WIDTH'(idx - seg_base);

    // at a segment end, hop to the base of the next enabled segment
    always_comb begin
        next_idx = idx + ONE;
        last     = 1'b0;
        if (idx == seg_last) begin
            if (seg < SEG_IIR && seg_en[EN_IIR]) begin
                next_idx = BASE_IIR;
            end else if (seg < SEG_CIC && seg_en[EN_CIC]) begin
                next_idx = BASE_CIC;
            end else if (seg < SEG_CTRL && seg_en[EN_CTRL]) begin
                next_idx = BASE_CTRL;
            end else begin
                next_idx = '0;
                last     = 1'b1;
            end
        end
    end

    always_comb begin
        first_idx = '0;
        none      = 1'b0;
        if (seg_en[EN_FRAC]) begin
            first_idx = '0;
        end else if (seg_en[EN_IIR]) begin
            first_idx = BASE_IIR;
        end else if (seg_en[EN_CIC]) begin
            first_idx = BASE_CIC;
        end else if (seg_en[EN_CTRL]) begin
            first_idx = BASE_CTRL;
        end else begin
            none = 1'b1;
        end
    end

endmodule

// File: rtl/dfe_cfg_sequencer.sv
// Boot-time sequencer: streams coefficient ROM words onto the chain's
// APB master port, with optional read-back compare.
module dfe_cfg_sequencer
    import dfe_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH  = 7,
    parameter int PDATA_WIDTH = 32,
    parameter int COEFF_WIDTH = 20,
    parameter int COMP        = 4,
    parameter int N_TAP       = IDX_IIR - IDX_FRAC,
    parameter int NUM_DENUM   = (IDX_CIC - IDX_IIR) / N_IIR_SEC,
    parameter int ROM_AW      = 7
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [3:0]                    seg_en,
    input  logic                          verify_en,
    output logic                          rom_en,
    output logic [ROM_AW-1:0]             rom_addr,
    input  logic [COEFF_WIDTH-1:0]        rom_data,
    output logic                          MTRANS,
    output logic                          MWRITE,
    output logic [COMP-1:0]               MSELx,
    output logic [ADDR_WIDTH-1:0]         MADDR,
    output logic signed [COEFF_WIDTH-1:0] MWDATA,
    input  logic [PDATA_WIDTH-1:0]        MRDATA,
    output logic                          busy,
    output logic                          done,
    output logic                          aborted,
    output logic                          err,
    output logic [ROM_AW-1:0]             err_idx
);

    state_t                state;
    state_t                state_n;
    logic [ROM_AW-1:0]     idx;
    logic [ROM_AW-1:0]     idx_n;
    logic [3:0]            seg_q;
    logic                  verify_q;
    logic                  abort_q;
    logic [3:0]            map_en;
    logic [COMP-1:0]       msel;
    logic [ADDR_WIDTH-1:0] maddr;
    logic [ROM_AW-1:0]     next_idx;
    logic [ROM_AW-1:0]     first_idx;
    logic                  last;
    logic                  none;
    logic                  go;
    logic                  stop;
    logic                  end_word;
    logic                  mismatch;
    logic                  bus_n;
    logic                  wr_n;

    logic [PDATA_WIDTH-COEFF_WIDTH-1:0] unused_rdata;

    // live enables pick the first word; the captured copy drives the run
    assign map_en = (state == IDLE) ? seg_en : seg_q;

    dfe_cfg_seg_map #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .COMP       (COMP),
        .ROM_AW     (ROM_AW),
        .N_TAP      (N_TAP),
        .NUM_DENUM  (NUM_DENUM)
    ) u_map (
        .idx       (idx),
        .seg_en    (map_en),
        .msel      (msel),
        .maddr     (maddr),
        .next_idx  (next_idx),
        .last      (last),
        .first_idx (first_idx),
        .none      (none)
    );

    assign unused_rdata = MRDATA[PDATA_WIDTH-1:COEFF_WIDTH];
    assign mismatch     = MRDATA[COEFF_WIDTH-1:0] != $unsigned(MWDATA);
    assign go           = (state == IDLE) && start;
    assign stop         = abort_q || abort;
    assign bus_n        = state_n inside {WR1, WR2, RD1, RD2};
    assign wr_n         = state_n inside {WR1, WR2};

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        end_word = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = none ? DONE : FETCH;
                    idx_n   = first_idx;
                end
            end
            FETCH:   state_n = LOAD;
            LOAD:    state_n = WR1;
            WR1:     state_n = WR2;
            WR2: begin
                if (verify_q) state_n = RD1;
                else          end_word = 1'b1;
            end
            RD1:     state_n = RD2;
            RD2:     state_n = CMP;
            CMP:     end_word = 1'b1;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (end_word) begin
            if (stop || last) begin
                state_n = DONE;
            end else begin
                state_n = FETCH;
                idx_n   = next_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            seg_q    <= '0;
            verify_q <= 1'b0;
            abort_q  <= 1'b0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            MTRANS   <= 1'b0;
            MWRITE   <= 1'b0;
            MSELx    <= '0;
            MADDR    <= '0;
            MWDATA   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            err      <= 1'b0;
            err_idx  <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            busy     <= state_n != IDLE;
            done     <= state_n == DONE;
            rom_en   <= state_n == FETCH;
            rom_addr <= (state_n == FETCH) ? idx_n : '0;
            MTRANS   <= bus_n;
            MWRITE   <= wr_n;
            MSELx    <= bus_n ? msel : '0;
            MADDR    <= bus_n ? maddr : '0;
            if (state == LOAD) MWDATA <= rom_data;
            if (state == IDLE || state_n == IDLE || state_n == DONE) begin
                abort_q <= 1'b0;
            end else begin
                abort_q <= stop;
            end
            if (go) begin
                seg_q    <= seg_en;
                verify_q <= verify_en;
                err      <= 1'b0;
                err_idx  <= '0;
                aborted  <= 1'b0;
            end
            if (end_word && stop) aborted <= 1'b1;
            if (state == CMP && mismatch && !err) begin
                err     <= 1'b1;
                err_idx <= idx;
            end
        end
    end

endmodule

// File: tb/tb_dfe_cfg_sequencer.sv
// Bench for dfe_cfg_sequencer: ROM/APB slave models and a layout-level
// reference of the expected write/read stream.
module tb_dfe_cfg_sequencer;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [3:0]        seg_en;
    logic              verify_en;
    logic              rom_en;
    logic [6:0]        rom_addr;
    logic [19:0]       rom_data;
    logic              MTRANS;
    logic              MWRITE;
    logic [3:0]        MSELx;
    logic [6:0]        MADDR;
    logic signed [19:0] MWDATA;
    logic [31:0]       MRDATA;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              err;
    logic [6:0]        err_idx;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dfe_cfg_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .seg_en    (seg_en),
        .verify_en (verify_en),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .MTRANS    (MTRANS),
        .MWRITE    (MWRITE),
        .MSELx     (MSELx),
        .MADDR     (MADDR),
        .MWDATA    (MWDATA),
        .MRDATA    (MRDATA),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .err       (err),
        .err_idx   (err_idx)
    );

    // ROM layout as a table: first/last index of FRAC, IIR, CIC, CTRL
    int seg_lo [4] = '{0, 72, 87, 88};
    int seg_hi [4] = '{71, 86, 87, 88};

    logic [19:0] rom [0:127];
    bit          bad [0:127];
    logic [19:0] mem [0:15][0:127];

    function automatic int seg_of(int i);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++)
            if (i >= seg_lo[k]) s = k;
        return s;
    endfunction

    function automatic int idx_of(logic [3:0] sel, logic [6:0] addr);
        for (int k = 0; k < 4; k++)
            if (sel == 4'(1 << k)) return seg_lo[k] + int'(addr);
        return 127;
    endfunction

    always @(posedge clk)
        rom_data <= rom_en ? rom[rom_addr] : 20'($urandom);

    always @(posedge clk) begin
        if (MTRANS && MWRITE) mem[MSELx][MADDR] <= MWDATA;
        if (MTRANS && !MWRITE)
            MRDATA <= {12'($urandom), mem[MSELx][MADDR] ^
                       (bad[idx_of(MSELx, MADDR)] ? 20'h1 : 20'h0)};
        else
            MRDATA <= $urandom;
    end

    typedef struct {
        int          cyc;
        bit          wr;
        logic [3:0]  sel;
        logic [6:0]  addr;
        logic [19:0] data;
    } beat_t;

    beat_t beats[$];
    int    fetch_idx[$];
    int    done_cyc;
    bit    mon_on = 1'b0;
    time   t0;
    int    exp_idx[$];

    always @(negedge clk) begin
        int    c;
        beat_t b;
        if (mon_on) begin
            c = int'(($time - t0 + 5) / 10);
            if (MTRANS) begin
                b.cyc  = c;
                b.wr   = MWRITE;
                b.sel  = MSELx;
                b.addr = MADDR;
                b.data = MWDATA;
                beats.push_back(b);
            end
            if (rom_en) fetch_idx.push_back(int'(rom_addr));
            if (done && done_cyc < 0) done_cyc = c;
        end
    end

    task automatic model(input logic [3:0] seg);
        exp_idx.delete();
        for (int s = 0; s < 4; s++)
            if (seg[s])
                for (int i = seg_lo[s]; i <= seg_hi[s]; i++)
                    exp_idx.push_back(i);
    endtask

    task automatic do_run(input logic [3:0] seg, input bit ver,
                          input int abort_cyc, input int restart_cyc,
                          input int budget);
        beats.delete();
        fetch_idx.delete();
        done_cyc = -1;
        @(negedge clk);
        seg_en    = seg;
        verify_en = ver;
        start     = 1'b1;
        @(posedge clk);
        t0     = $time;
        mon_on = 1'b1;
        #1;
        start     = 1'b0;
        seg_en    = 4'($urandom);
        verify_en = 1'($urandom);
        for (int k = 1; k <= budget; k++) begin
            start = (k == restart_cyc);
            abort = (k == abort_cyc);
            @(posedge clk);
            #1;
            if (done_cyc >= 0 && k > done_cyc) break;
        end
        start  = 1'b0;
        abort  = 1'b0;
        mon_on = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, aborted, err, err_idx, rom_en, rom_addr, MTRANS,
             MWRITE, MSELx, MADDR, MWDATA} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs busy=%b MTRANS=%b",
                     busy, MTRANS);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || MTRANS !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b MTRANS=%b want 0 0", busy, MTRANS);
        end
    endtask

    task automatic test_full_load;
        int w, ph, i, s, nb;
        for (int k = 0; k < 128; k++) rom[k] = 20'($urandom);
        model(4'b1111);
        do_run(4'b1111, 1'b0, 0, 0, 400);
        checks++;
        if (done_cyc != 357) begin
            errors++;
            $display("FAIL full_done_cyc: got %0d want 357", done_cyc);
        end
        checks++;
        if (beats.size() != 178) begin
            errors++;
            $display("FAIL full_beats: got %0d want 178", beats.size());
        end
        nb = (beats.size() < 178) ? beats.size() : 178;
        for (int j = 0; j < nb; j++) begin
            w  = j / 2;
            ph = j % 2;
            i  = exp_idx[w];
            s  = seg_of(i);
            checks++;
            if (beats[j].cyc != 3 + 4 * w + ph || beats[j].wr !== 1'b1 ||
                beats[j].sel !== 4'(1 << s) ||
                beats[j].addr !== 7'(i - seg_lo[s]) ||
                beats[j].data !== rom[i]) begin
                errors++;
                $display("FAIL full_beat[%0d]: got cyc=%0d sel=%h addr=%0d data=%h want cyc=%0d sel=%h addr=%0d data=%h",
                         j, beats[j].cyc, beats[j].sel, beats[j].addr,
                         beats[j].data, 3 + 4 * w + ph, 4'(1 << s),
                         i - seg_lo[s], rom[i]);
            end
        end
        checks++;
        if (nb == 0 || beats[nb-1].sel !== 4'b1000 || beats[nb-1].addr !== 7'd0) begin
            errors++;
            $display("FAIL full_last_write: got sel=%h addr=%0d want 8 0",
                     (nb > 0) ? beats[nb-1].sel : 4'h0,
                     (nb > 0) ? beats[nb-1].addr : 7'd0);
        end
    endtask

    task automatic test_cic_verify;
        rom[87] = 20'd5;
        do_run(4'b0100, 1'b1, 0, 0, 30);
        checks++;
        if (done_cyc != 8) begin
            errors++;
            $display("FAIL cic_done_cyc: got %0d want 8", done_cyc);
        end
        checks++;
        if (beats.size() != 4) begin
            errors++;
            $display("FAIL cic_beats: got %0d want 4", beats.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (beats[j].cyc != 3 + j || beats[j].wr !== (j < 2) ||
                    beats[j].sel !== 4'b0100 || beats[j].addr !== 7'd0 ||
                    (j < 2 && beats[j].data !== 20'd5)) begin
                    errors++;
                    $display("FAIL cic_beat[%0d]: got cyc=%0d wr=%b sel=%h addr=%0d data=%0d want cyc=%0d wr=%b sel=4 addr=0 data=5",
                             j, beats[j].cyc, beats[j].wr, beats[j].sel,
                             beats[j].addr, beats[j].data, 3 + j, j < 2);
                end
            end
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL cic_err: got %b want 0", err);
        end
    endtask

    task automatic test_mismatch;
        bad[78] = 1'b1;
        bad[81] = 1'b1;
        do_run(4'b0010, 1'b1, 0, 0, 130);
        bad[78] = 1'b0;
        bad[81] = 1'b0;
        checks++;
        if (err !== 1'b1 || err_idx !== 7'd78) begin
            errors++;
            $display("FAIL mismatch_err: got err=%b idx=%0d want 1 78", err, err_idx);
        end
        checks++;
        if (done_cyc != 106 || fetch_idx.size() != 15 || beats.size() != 60) begin
            errors++;
            $display("FAIL mismatch_run: got done=%0d fetches=%0d beats=%0d want 106 15 60",
                     done_cyc, fetch_idx.size(), beats.size());
        end
    endtask

    task automatic test_abort;
        do_run(4'b0001, 1'b0, 43, 0, 60);
        checks++;
        if (aborted !== 1'b1) begin
            errors++;
            $display("FAIL abort_flag: got %b want 1", aborted);
        end
        checks++;
        if (done_cyc != 45 || fetch_idx.size() != 11 || beats.size() != 22) begin
            errors++;
            $display("FAIL abort_run: got done=%0d fetches=%0d beats=%0d want 45 11 22",
                     done_cyc, fetch_idx.size(), beats.size());
        end
        checks++;
        if (beats.size() == 0 || beats[beats.size()-1].addr !== 7'd10 ||
            beats[beats.size()-1].cyc != 44) begin
            errors++;
            $display("FAIL abort_last_beat: got addr=%0d cyc=%0d want 10 44",
                     (beats.size() > 0) ? beats[beats.size()-1].addr : 7'd0,
                     (beats.size() > 0) ? beats[beats.size()-1].cyc : 0);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL abort_err_cleared: got %b want 0", err);
        end
    endtask

    task automatic test_restart_ignored;
        model(4'b0011);
        do_run(4'b0011, 1'b0, 0, 20, 400);
        checks++;
        if (done_cyc != 349 || beats.size() != 174) begin
            errors++;
            $display("FAIL restart_run: got done=%0d beats=%0d want 349 174",
                     done_cyc, beats.size());
        end
        checks++;
        if (fetch_idx.size() != exp_idx.size() || (fetch_idx.size() > 20 &&
            fetch_idx[20] != exp_idx[20])) begin
            errors++;
            $display("FAIL restart_fetch: got %0d fetches want %0d",
                     fetch_idx.size(), exp_idx.size());
        end
        checks++;
        if (aborted !== 1'b0) begin
            errors++;
            $display("FAIL restart_aborted_cleared: got %b want 0", aborted);
        end
    endtask

    task automatic test_seg_zero;
        do_run(4'b0000, 1'b1, 0, 0, 10);
        checks++;
        if (done_cyc != 1 || beats.size() != 0 || fetch_idx.size() != 0) begin
            errors++;
            $display("FAIL seg_zero: got done=%0d beats=%0d fetches=%0d want 1 0 0",
                     done_cyc, beats.size(), fetch_idx.size());
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        seg_en    = 4'b1111;
        verify_en = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (MTRANS !== 1'b1 || MSELx !== 4'b0001 || MADDR !== 7'd1) begin
            errors++;
            $display("FAIL midreset_wr1: got MTRANS=%b sel=%h addr=%0d want 1 1 1",
                     MTRANS, MSELx, MADDR);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, aborted, err, err_idx, rom_en, rom_addr, MTRANS,
             MWRITE, MSELx, MADDR, MWDATA} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b MTRANS=%b sel=%h want all 0",
                     busy, MTRANS, MSELx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_run(4'b0011, 1'b0, 0, 0, 400);
        checks++;
        if (fetch_idx.size() == 0 || fetch_idx[0] != 0 || done_cyc != 349) begin
            errors++;
            $display("FAIL midreset_restart: got first=%0d done=%0d want 0 349",
                     (fetch_idx.size() > 0) ? fetch_idx[0] : -1, done_cyc);
        end
    endtask

    task automatic test_random;
        logic [3:0] seg;
        bit         ver;
        int         p, bpw, n, w, ph, i, s, nb;
        bit         e_err;
        int         e_idx;
        for (int it = 0; it < 6; it++) begin
            seg = 4'($urandom_range(1, 15));
            ver = 1'($urandom);
            for (int k = 0; k < 128; k++) begin
                rom[k] = 20'($urandom);
                bad[k] = ver && ($urandom_range(0, 19) == 0);
            end
            model(seg);
            n     = exp_idx.size();
            p     = ver ? 7 : 4;
            bpw   = ver ? 4 : 2;
            e_err = 1'b0;
            e_idx = 0;
            for (int k = 0; k < n; k++)
                if (bad[exp_idx[k]] && !e_err) begin
                    e_err = 1'b1;
                    e_idx = exp_idx[k];
                end
            do_run(seg, ver, 0, 0, 1 + n * p + 20);
            for (int k = 0; k < 128; k++) bad[k] = 1'b0;
            checks++;
            if (done_cyc != 1 + n * p || beats.size() != n * bpw) begin
                errors++;
                $display("FAIL rand%0d_run: got done=%0d beats=%0d want %0d %0d",
                         it, done_cyc, beats.size(), 1 + n * p, n * bpw);
            end
            checks++;
            if (err !== e_err || err_idx !== 7'(e_idx)) begin
                errors++;
                $display("FAIL rand%0d_err: got err=%b idx=%0d want %b %0d",
                         it, err, err_idx, e_err, e_idx);
            end
            nb = (beats.size() < n * bpw) ? beats.size() : n * bpw;
            for (int j = 0; j < nb; j++) begin
                w  = j / bpw;
                ph = j % bpw;
                i  = exp_idx[w];
                s  = seg_of(i);
                checks++;
                if (beats[j].cyc != 3 + p * w + ph || beats[j].wr !== (ph < 2) ||
                    beats[j].sel !== 4'(1 << s) ||
                    beats[j].addr !== 7'(i - seg_lo[s]) ||
                    (ph < 2 && beats[j].data !== rom[i])) begin
                    errors++;
                    $display("FAIL rand%0d_beat[%0d]: got cyc=%0d wr=%b sel=%h addr=%0d data=%h want cyc=%0d wr=%b sel=%h addr=%0d data=%h",
                             it, j, beats[j].cyc, beats[j].wr, beats[j].sel,
                             beats[j].addr, beats[j].data, 3 + p * w + ph,
                             ph < 2, 4'(1 << s), i - seg_lo[s], rom[i]);
                end
            end
        end
    endtask

    initial begin
        start     = 1'b0;
        abort     = 1'b0;
        seg_en    = 4'b0000;
        verify_en = 1'b0;
        for (int k = 0; k < 128; k++) begin
            rom[k] = '0;
            bad[k] = 1'b0;
        end
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 128; b++)
                mem[a][b] = '0;
        test_reset();
        test_full_load();
        test_cic_verify();
        test_mismatch();
        test_abort();
        test_restart_ignored();
        test_seg_zero();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
